// File: rtl/zone_sensor_conditioner.sv
// rtl/zone_sensor_conditioner.sv - perimeter sensor front end: sync, per-zone debounce,
// edge pulses, glitch counting and stuck-active detection.
module zone_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_CYCLES    = 1000,
    parameter int GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          raw_zone,
    output logic [3:0]          zone,
    output logic [3:0]          zone_rise,
    output logic [3:0]          zone_fall,
    output logic [GLITCH_W-1:0] glitch_cnt,
    output logic [3:0]          stuck_fault
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = $clog2(STUCK_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_CYCLES);

    logic [3:0]          sync1_q, sync2_q;
    logic [3:0]          zone_q, zone_d;
    logic [3:0]          rise_q, rise_d;
    logic [3:0]          fall_q, fall_d;
    logic [3:0][CW-1:0]  cnt_q, cnt_d;
    logic [3:0][SW-1:0]  scnt_q, scnt_d;
    logic [3:0]          fault_q, fault_d;
    logic [3:0]          glitched;
    logic [GLITCH_W-1:0] glitch_q, glitch_d;

    always_comb begin
        zone_d   = zone_q;
        cnt_d    = cnt_q;
        scnt_d   = scnt_q;
        fault_d  = fault_q;
        glitched = '0;
        for (int i = 0; i < 4; i++) begin
            // A line that returns to the accepted level mid-count is a rejected glitch.
            if (sync2_q[i] == zone_q[i]) begin
                cnt_d[i]    = '0;
                glitched[i] = (cnt_q[i] != '0);
            end else if (cnt_q[i] == DEB_LAST) begin
                zone_d[i] = sync2_q[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end

            // Stuck tracking follows the accepted level and resets on the falling edge.
            if (!zone_d[i]) begin
                scnt_d[i]  = '0;
                fault_d[i] = 1'b0;
            end else begin
                if (zone_q[i] && (scnt_q[i] != STUCK_MAX)) begin
                    scnt_d[i] = scnt_q[i] + SW'(1);
                end
                fault_d[i] = fault_q[i] | (scnt_d[i] == STUCK_MAX);
            end
        end
        rise_d   = zone_d & ~zone_q;
        fall_d   = zone_q & ~zone_d;
        glitch_d = glitch_q;
        if ((|glitched) && (glitch_q != {GLITCH_W{1'b1}})) begin
            glitch_d = glitch_q + GLITCH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            zone_q   <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            cnt_q    <= '0;
            scnt_q   <= '0;
            fault_q  <= '0;
            glitch_q <= '0;
        end else begin
            sync1_q  <= raw_zone;
            sync2_q  <= sync1_q;
            zone_q   <= zone_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            cnt_q    <= cnt_d;
            scnt_q   <= scnt_d;
            fault_q  <= fault_d;
            glitch_q <= glitch_d;
        end
    end

    assign zone        = zone_q;
    assign zone_rise   = rise_q;
    assign zone_fall   = fall_q;
    assign glitch_cnt  = glitch_q;
    assign stuck_fault = fault_q;

endmodule
